instr_decode: RTL

Command decoder that sits directly downstream of the SPI bridge. It turns the stream of received bytes into register read and write strobes for the PWM peripheral register file. It also returns read data to the bridge for shifting out on MISO. Every SPI transaction is exactly two bytes: a command byte followed by a data byte.

---
 rtl/instr_decode.sv | 76 +++++++
 1 files changed

// File: rtl/instr_decode.sv
// Two-byte SPI command decoder: command byte selects register/lane/direction,
// data byte completes a write; reads are strobed right after the command byte.
module instr_decode (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       byte_sync,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic       hi_sel,
    input  logic [7:0] data_read,
    output logic [7:0] data_write
);

    typedef enum logic {IDLE, DATA} state_t;

    state_t     state_q;
    logic       wr_cmd_q;
    logic       read_q;
    logic       write_q;
    logic [5:0] addr_q;
    logic       hi_q;
    logic [7:0] dout_q;
    logic [7:0] dwr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_cmd_q <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            hi_q     <= 1'b0;
            dout_q   <= '0;
            dwr_q    <= '0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            // Capture happens in the strobe cycle even if the frame aborts meanwhile.
            if (read_q)
                dout_q <= data_read;
            if (byte_sync) begin
                case (state_q)
                    IDLE: begin
                        addr_q   <= data_in[5:0];
                        hi_q     <= data_in[6];
                        wr_cmd_q <= data_in[7];
                        read_q   <= ~data_in[7];
                        state_q  <= DATA;
                    end
                    DATA: begin
                        if (wr_cmd_q) begin
                            dwr_q   <= data_in;
                            write_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (cs_n) begin
                state_q <= IDLE;
            end
        end
    end

    assign data_out   = dout_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign hi_sel     = hi_q;
    assign data_write = dwr_q;

endmodule
